sram_row_streamer: RTL and testbench

SRAM_ROW_STREAMER -- requirements
Module: sram_row_streamer

---
 rtl/sram_row_streamer.sv | 156 +++++++++++++++
 tb/tb_sram_row_streamer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_row_streamer.sv
// sram_row_streamer: reads a run of consecutive SRAM rows and streams them out
// over a valid/ready interface through a 2-entry buffer.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START             one-cycle launch pulse, only honoured while idle
//   BASE_ADDR, LEN    first row address and row count (0..2^AWIDTH), captured on START
//   CSn, WEn, ADDR,   SRAM read port; CSn low only on read cycles, WEn tied high,
//   BE, D_out         BE all-ones, D_out valid combinationally with ADDR
//   OUT_VALID/READY   stream handshake
//   OUT_DATA/LAST     head row of the buffer and its end-of-transfer flag
//   BUSY, DONE        not-idle flag, one-cycle completion pulse
module sram_row_streamer #(
   parameter int unsigned BWIDTH = 256,
   parameter int unsigned AWIDTH = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [AWIDTH-1:0] BASE_ADDR,
   input  logic [AWIDTH:0]   LEN,
   output logic              CSn,
   output logic              WEn,
   output logic [AWIDTH-1:0] ADDR,
   output logic [BWIDTH-1:0] BE,
   input  logic [BWIDTH-1:0] D_out,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [BWIDTH-1:0] OUT_DATA,
   output logic              OUT_LAST,
   output logic              BUSY,
   output logic              DONE
);

   localparam logic [AWIDTH:0] One = 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e              state_q, state_d;
   logic [AWIDTH-1:0]   base_q, base_d;
   logic [AWIDTH:0]     len_q, len_d;
   logic [AWIDTH:0]     idx_q, idx_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic                done_q, done_d;

   // Buffer: entry 0 is always the head.
   logic [BWIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
   logic                last0_q, last0_d, last1_q, last1_d;
   logic [1:0]          count_q, count_d;

   logic                rd, push, pop, last_in;
   logic [1:0]          wpos;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      rd      = 1'b0;
      push    = 1'b0;
      last_in = 1'b0;
      pop     = (count_q != 2'd0) && OUT_READY;

      unique case (state_q)
         StIdle: begin
            if (START) begin
               if (LEN == '0) begin
                  done_d = 1'b1;
               end else begin
                  base_d  = BASE_ADDR;
                  len_d   = LEN;
                  idx_d   = '0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            // A full buffer can still take a row if the head leaves this cycle.
            if ((count_q != 2'd2) || pop) begin
               rd      = 1'b1;
               push    = 1'b1;
               last_in = (idx_q == len_q - One);
               idx_d   = idx_q + One;
               if (last_in) state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && last0_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Wraps naturally modulo 2^AWIDTH.
      ADDR   = rd ? (base_q + idx_q[AWIDTH-1:0]) : addr_q;
      addr_d = ADDR;

      // Pop shifts entry 1 forward; push lands in the first free slot after the pop.
      data0_d = pop ? data1_q : data0_q;
      last0_d = pop ? last1_q : last0_q;
      data1_d = data1_q;
      last1_d = last1_q;
      wpos    = count_q - {1'b0, pop};
      if (push) begin
         if (wpos == 2'd0) begin
            data0_d = D_out;
            last0_d = last_in;
         end else begin
            data1_d = D_out;
            last1_d = last_in;
         end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         count_q <= count_d;
      end
   end

   assign CSn       = ~rd;
   assign WEn       = 1'b1;
   assign BE        = '1;
   assign OUT_VALID = (count_q != 2'd0);
   assign OUT_DATA  = data0_q;
   assign OUT_LAST  = OUT_VALID && last0_q;
   assign BUSY      = (state_q != StIdle);
   assign DONE      = done_q;

endmodule

// File: tb/tb_sram_row_streamer.sv
module tb_sram_row_streamer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [9:0]   base_addr = '0;
   logic [10:0]  len = '0;
   logic         out_ready = 1'b0;
   logic         csn, wen, out_valid, out_last, busy, done;
   logic [9:0]   addr;
   logic [255:0] be, d_out, out_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Observed events
   logic [9:0]   rd_addr_q[$];
   int           rd_cyc_q[$];
   logic [255:0] got_data_q[$];
   bit           got_last_q[$];
   int           beat_cyc_q[$];
   int           done_cnt;
   int           done_cyc;
   int           busy_cnt;
   // Scoreboard
   logic [255:0] exp_data_q[$];
   bit           exp_last_q[$];

   function automatic logic [255:0] row_of(input logic [9:0] a);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = {16'hC0DE ^ 16'(i), 6'd0, a};
      return r;
   endfunction

   assign d_out = row_of(addr);

   always #5 clk = ~clk;

   sram_row_streamer dut (
      .CLK(clk), .RST(rst), .START(start), .BASE_ADDR(base_addr), .LEN(len),
      .CSn(csn), .WEn(wen), .ADDR(addr), .BE(be), .D_out(d_out),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
      .OUT_LAST(out_last), .BUSY(busy), .DONE(done)
   );

   task automatic clear_obs();
      rd_addr_q.delete(); rd_cyc_q.delete();
      got_data_q.delete(); got_last_q.delete(); beat_cyc_q.delete();
      exp_data_q.delete(); exp_last_q.delete();
      done_cnt = 0; done_cyc = -1; busy_cnt = 0;
   endtask

   // Push the expected rows of a transfer onto the scoreboard.
   task automatic expect_xfer(input logic [9:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_data_q.push_back(row_of(b + 10'(i)));
         exp_last_q.push_back(i == n - 1);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and record what the DUT does.
   task automatic step(input bit r, input bit rdy, input bit s, input logic [9:0] b,
                       input logic [10:0] l);
      @(negedge clk);
      rst = r; out_ready = rdy; start = s; base_addr = b; len = l;
      #1;
      cyc++;
      if (!csn) begin rd_addr_q.push_back(addr); rd_cyc_q.push_back(cyc); end
      if (out_valid && out_ready && !r) begin
         got_data_q.push_back(out_data);
         got_last_q.push_back(out_last);
         beat_cyc_q.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) step(0, 1, 0, 0, 0);
      checks++;
      if (done_cnt == 0) begin
         failures++;
         $display("FAIL done_timeout: DONE not seen within %0d cycles", budget);
      end
   endtask

   task automatic compare_beats(input string tag);
      logic [255:0] gd, ed;
      bit gl, el;
      while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
         gd = got_data_q.pop_front(); ed = exp_data_q.pop_front();
         gl = got_last_q.pop_front(); el = exp_last_q.pop_front();
         checks++;
         if (gd !== ed) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", tag, gd[31:0], ed[31:0]);
         end
         checks++;
         if (gl !== el) begin
            failures++;
            $display("FAIL %s_last: got %0b want %0b", tag, gl, el);
         end
      end
      checks++;
      if (got_data_q.size() != 0 || exp_data_q.size() != 0) begin
         failures++;
         $display("FAIL %s_count: extra got %0d, missing %0d", tag, got_data_q.size(),
                  exp_data_q.size());
      end
   endtask

   task automatic check_addrs(input string tag, input logic [9:0] b, input int n);
      checks++;
      if (rd_addr_q.size() != n) begin
         failures++;
         $display("FAIL %s_nreads: got %0d want %0d", tag, rd_addr_q.size(), n);
      end
      for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
         checks++;
         if (rd_addr_q[i] !== b + 10'(i)) begin
            failures++;
            $display("FAIL %s_addr%0d: got %h want %h", tag, i, rd_addr_q[i], b + 10'(i));
         end
      end
   endtask

   task automatic test_reset();
      clear_obs();
      repeat (3) step(1, 0, 0, 0, 0);
      checks++;
      if ({csn, wen, addr, out_valid, out_last, busy, done} !== {1'b1, 1'b1, 10'h0, 4'b0}) begin
         failures++;
         $display("FAIL reset_outputs: got csn=%b wen=%b addr=%h v=%b l=%b busy=%b done=%b",
                  csn, wen, addr, out_valid, out_last, busy, done);
      end
      checks++;
      if (be !== {256{1'b1}}) begin
         failures++;
         $display("FAIL reset_be: got %h want all ones", be[31:0]);
      end
   endtask

   task automatic test_basic();
      clear_obs();
      expect_xfer(10'h010, 4);
      step(0, 1, 1, 10'h010, 11'd4);
      run_until_done(30);
      check_addrs("basic", 10'h010, 4);
      checks++;
      if (rd_cyc_q.size() == 4 && rd_cyc_q[3] - rd_cyc_q[0] != 3) begin
         failures++;
         $display("FAIL basic_read_span: got %0d want 3", rd_cyc_q[3] - rd_cyc_q[0]);
      end
      checks++;
      if (beat_cyc_q.size() != 4 || beat_cyc_q[3] - beat_cyc_q[0] != 3
          || beat_cyc_q[0] != rd_cyc_q[0] + 1) begin
         failures++;
         $display("FAIL basic_beat_timing: got %0d beats", beat_cyc_q.size());
      end
      checks++;
      if (beat_cyc_q.size() == 4 && done_cyc != beat_cyc_q[3] + 1) begin
         failures++;
         $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, beat_cyc_q[3] + 1);
      end
      compare_beats("basic");
      step(0, 1, 0, 0, 0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle_after: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_stall();
      logic [255:0] hold;
      logic hold_last;
      bit have = 0;
      clear_obs();
      expect_xfer(10'h080, 4);
      step(0, 0, 1, 10'h080, 11'd4);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0);
         if (out_valid) begin
            if (!have) begin
               hold = out_data; hold_last = out_last; have = 1;
            end else begin
               checks++;
               if (out_data !== hold || out_last !== hold_last) begin
                  failures++;
                  $display("FAIL stall_stable: got %h want %h", out_data[31:0], hold[31:0]);
               end
            end
         end
      end
      checks++;
      if (rd_addr_q.size() != 2) begin
         failures++;
         $display("FAIL stall_reads: got %0d want 2", rd_addr_q.size());
      end
      run_until_done(30);
      check_addrs("stall", 10'h080, 4);
      compare_beats("stall");
   endtask

   task automatic test_wrap();
      clear_obs();
      expect_xfer(10'h3FE, 3);
      step(0, 1, 1, 10'h3FE, 11'd3);
      run_until_done(30);
      check_addrs("wrap", 10'h3FE, 3);
      compare_beats("wrap");
   endtask

   task automatic test_len0();
      clear_obs();
      step(0, 1, 1, 10'h123, 11'd0);
      step(0, 1, 0, 0, 0);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL len0_done: got %b want 1", done);
      end
      repeat (3) step(0, 1, 0, 0, 0);
      checks++;
      if (rd_addr_q.size() != 0 || busy_cnt != 0 || done_cnt != 1) begin
         failures++;
         $display("FAIL len0_quiet: got reads=%0d busy=%0d dones=%0d want 0 0 1",
                  rd_addr_q.size(), busy_cnt, done_cnt);
      end
   endtask

   task automatic test_abort();
      clear_obs();
      step(0, 1, 1, 10'h020, 11'd8);
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || csn !== 1'b1) begin
         failures++;
         $display("FAIL abort_state: got busy=%b valid=%b csn=%b want 0 0 1",
                  busy, out_valid, csn);
      end
      repeat (10) step(0, 1, 0, 0, 0);
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
      end
      clear_obs();
      expect_xfer(10'h040, 2);
      step(0, 1, 1, 10'h040, 11'd2);
      run_until_done(30);
      check_addrs("restart", 10'h040, 2);
      compare_beats("restart");
   endtask

   task automatic test_ignore_start();
      clear_obs();
      expect_xfer(10'h100, 5);
      step(0, 1, 1, 10'h100, 11'd5);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 10'h200, 11'd3);
      run_until_done(30);
      check_addrs("ignore", 10'h100, 5);
      compare_beats("ignore");
   endtask

   task automatic test_random_ready();
      clear_obs();
      expect_xfer(10'h155, 6);
      step(0, 0, 1, 10'h155, 11'd6);
      for (int i = 0; i < 200 && done_cnt == 0; i++) step(0, 1'($urandom_range(0, 1)), 0, 0, 0);
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL random_done: got %0d pulses want 1", done_cnt);
      end
      check_addrs("random", 10'h155, 6);
      compare_beats("random");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_len0();
      test_abort();
      test_ignore_start();
      test_random_ready();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
